// File: rtl/vend_ctrl.sv
// Drink vending machine transaction controller.
// Accumulates coin credit in 0.5-yuan units, arbitrates product selection
// against per-slot price and stock, runs the dispense motor handshake and
// then pays out change through the coin hopper. Every output is registered.
module vend_ctrl #(
  parameter int CREDIT_W  = 5,
  parameter int PRICE_W   = 4,
  parameter int STOCK_W   = 4,
  parameter int STOCK_MAX = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           coin,
  input  logic                 sel_vld,
  input  logic [1:0]           sel_id,
  input  logic                 cancel,
  input  logic                 restock,
  input  logic [4*PRICE_W-1:0] price_cfg,
  output logic                 disp_req,
  output logic [1:0]           disp_id,
  input  logic                 disp_ack,
  output logic                 pay_req,
  output logic [1:0]           pay_val,
  input  logic                 pay_ack,
  output logic [CREDIT_W-1:0]  credit,
  output logic                 busy,
  output logic                 coin_rej,
  output logic                 err_soldout,
  output logic                 err_funds
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    DISPENSE = 2'b01,
    CHANGE   = 2'b10
  } state_t;

  localparam logic [1:0] COIN_HALF = 2'b01;
  localparam logic [1:0] COIN_ONE  = 2'b10;

  // Credit arithmetic is done one bit wider so an overflowing coin is visible.
  localparam logic [CREDIT_W:0]  CREDIT_MAX = (CREDIT_W+1)'((1 << CREDIT_W) - 1);
  localparam logic [CREDIT_W:0]  AMT_ONE    = (CREDIT_W+1)'(1);
  localparam logic [CREDIT_W:0]  AMT_TWO    = (CREDIT_W+1)'(2);
  localparam logic [STOCK_W-1:0] STOCK_FULL = STOCK_W'(STOCK_MAX);
  localparam logic [STOCK_W-1:0] STOCK_ONE  = STOCK_W'(1);

  state_t              state, state_n;
  logic [STOCK_W-1:0]  stock   [4];
  logic [STOCK_W-1:0]  stock_n [4];
  logic [PRICE_W-1:0]  price   [4];

  logic [CREDIT_W-1:0] credit_n;
  logic                disp_req_n, pay_req_n, busy_n;
  logic                coin_rej_n, err_soldout_n, err_funds_n;
  logic [1:0]          disp_id_n, pay_val_n;

  logic [CREDIT_W:0]   coin_amt, credit_ext, credit_add, sel_price, change_left;

  assign credit_ext = {1'b0, credit};
  assign sel_price  = (CREDIT_W+1)'(price[sel_id]);

  // Coin to pay next: a whole yuan while at least two units remain.
  function automatic logic [1:0] coin_for(input logic [CREDIT_W:0] amt);
    return (amt >= AMT_TWO) ? COIN_ONE : COIN_HALF;
  endfunction

  // Unpack slot prices; a zero price is bumped to one unit.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      price[i] = price_cfg[i*PRICE_W +: PRICE_W];
      if (price[i] == '0) price[i] = PRICE_W'(1);
    end
  end

  // Decode the coin acceptor into credit units.
  always_comb begin
    case (coin)
      COIN_HALF: coin_amt = AMT_ONE;
      COIN_ONE:  coin_amt = AMT_TWO;
      default:   coin_amt = '0;
    endcase
  end

  // Next-state, credit, stock and registered-output computation.
  always_comb begin
    state_n       = state;
    credit_n      = credit;
    stock_n       = stock;
    disp_req_n    = disp_req;
    disp_id_n     = disp_id;
    pay_req_n     = pay_req;
    pay_val_n     = pay_val;
    coin_rej_n    = 1'b0;
    err_soldout_n = 1'b0;
    err_funds_n   = 1'b0;
    credit_add    = credit_ext;
    change_left   = credit_ext;

    case (state)
      IDLE: begin
        if (coin_amt != '0) begin
          if (credit_ext + coin_amt > CREDIT_MAX) coin_rej_n = 1'b1;
          else                                    credit_add = credit_ext + coin_amt;
        end
        credit_n = credit_add[CREDIT_W-1:0];

        if (restock) begin
          for (int unsigned i = 0; i < 4; i++) stock_n[i] = STOCK_FULL;
        end else if (cancel) begin
          if (credit != '0) begin
            state_n   = CHANGE;
            pay_req_n = 1'b1;
            pay_val_n = coin_for(credit_add);
          end
        end else if (sel_vld) begin
          if (stock[sel_id] == '0) begin
            err_soldout_n = 1'b1;
          end else if (credit_ext < sel_price) begin
            err_funds_n = 1'b1;
          end else begin
            // Affordability uses the old credit; the same-cycle coin still lands.
            credit_n        = CREDIT_W'(credit_add - sel_price);
            stock_n[sel_id] = stock[sel_id] - STOCK_ONE;
            disp_id_n       = sel_id;
            disp_req_n      = 1'b1;
            state_n         = DISPENSE;
          end
        end
      end

      DISPENSE: begin
        coin_rej_n = (coin_amt != '0);
        if (disp_ack) begin
          disp_req_n = 1'b0;
          disp_id_n  = '0;
          if (credit != '0) begin
            state_n   = CHANGE;
            pay_req_n = 1'b1;
            pay_val_n = coin_for(credit_ext);
          end else begin
            state_n = IDLE;
          end
        end
      end

      CHANGE: begin
        coin_rej_n = (coin_amt != '0);
        if (pay_ack) begin
          if (pay_val == COIN_ONE && credit_ext >= AMT_TWO) change_left = credit_ext - AMT_TWO;
          else if (credit != '0)                            change_left = credit_ext - AMT_ONE;
          else                                              change_left = '0;
          credit_n = change_left[CREDIT_W-1:0];
          if (change_left == '0) begin
            state_n   = IDLE;
            pay_req_n = 1'b0;
            pay_val_n = '0;
          end else begin
            pay_val_n = coin_for(change_left);
          end
        end
      end

      default: begin
        state_n    = IDLE;
        disp_req_n = 1'b0;
        disp_id_n  = '0;
        pay_req_n  = 1'b0;
        pay_val_n  = '0;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  // State, credit, stock and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      credit      <= '0;
      for (int unsigned i = 0; i < 4; i++) stock[i] <= '0;
      disp_req    <= 1'b0;
      disp_id     <= '0;
      pay_req     <= 1'b0;
      pay_val     <= '0;
      busy        <= 1'b0;
      coin_rej    <= 1'b0;
      err_soldout <= 1'b0;
      err_funds   <= 1'b0;
    end else begin
      state       <= state_n;
      credit      <= credit_n;
      stock       <= stock_n;
      disp_req    <= disp_req_n;
      disp_id     <= disp_id_n;
      pay_req     <= pay_req_n;
      pay_val     <= pay_val_n;
      busy        <= busy_n;
      coin_rej    <= coin_rej_n;
      err_soldout <= err_soldout_n;
      err_funds   <= err_funds_n;
    end
  end

endmodule

// File: tb/tb_vend_ctrl.sv
// Scoreboard bench for vend_ctrl: stimulus pushes expected events, a monitor
// pops and compares them whenever the controller presents an output.
module tb_vend_ctrl;

  logic        clk = 1'b0;
  logic        rst, sel_vld, cancel, restock, disp_ack, pay_ack;
  logic [1:0]  coin, sel_id;
  logic [15:0] price_cfg;
  logic        disp_req, pay_req, busy, coin_rej, err_soldout, err_funds;
  logic [1:0]  disp_id, pay_val;
  logic [4:0]  credit;

  always #5 clk = ~clk;

  vend_ctrl #(.CREDIT_W(5), .PRICE_W(4), .STOCK_W(4), .STOCK_MAX(15)) dut (
    .clk(clk), .rst(rst), .coin(coin), .sel_vld(sel_vld), .sel_id(sel_id),
    .cancel(cancel), .restock(restock), .price_cfg(price_cfg),
    .disp_req(disp_req), .disp_id(disp_id), .disp_ack(disp_ack),
    .pay_req(pay_req), .pay_val(pay_val), .pay_ack(pay_ack),
    .credit(credit), .busy(busy), .coin_rej(coin_rej),
    .err_soldout(err_soldout), .err_funds(err_funds)
  );

  typedef enum int {E_REJ, E_SOLD, E_FUNDS, E_DISP, E_PAY} evt_t;
  typedef struct { evt_t kind; int val; } evt_s;
  typedef enum int {P_CRED, P_RST, P_IDLE, P_BUSY, P_TO} prb_t;
  typedef struct { prb_t kind; int val; } prb_s;

  evt_s exp_q[$];
  prb_s prb_q[$];
  logic probe = 1'b0;
  logic done  = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_evt(input evt_t k, input int v);
    exp_q.push_back('{kind: k, val: v});
  endtask

  task automatic check(input prb_t k, input int v);
    prb_q.push_back('{kind: k, val: v});
    probe = 1'b1;
    tick();
    probe = 1'b0;
  endtask

  task automatic put_coin(input logic [1:0] c);
    coin = c;
    tick();
    coin = 2'b00;
  endtask

  task automatic select(input logic [1:0] id);
    sel_id  = id;
    sel_vld = 1'b1;
    tick();
    sel_vld = 1'b0;
  endtask

  task automatic pulse_cancel();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
  endtask

  task automatic pulse_restock();
    restock = 1'b1;
    tick();
    restock = 1'b0;
  endtask

  task automatic ack_dispense();
    int i = 0;
    while (!disp_req && i < 20) begin
      tick();
      i++;
    end
    if (!disp_req) check(P_TO, 0);
    disp_ack = 1'b1;
    tick();
    disp_ack = 1'b0;
  endtask

  task automatic pay_out(input int n);
    for (int k = 0; k < n; k++) begin
      int i = 0;
      while (!pay_req && i < 20) begin
        tick();
        i++;
      end
      if (!pay_req) begin
        check(P_TO, 1);
        return;
      end
      pay_ack = 1'b1;
      tick();
      pay_ack = 1'b0;
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic disp_prev = 1'b0;

  task automatic take(input evt_t k, input int v, input string nm);
    evt_s e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: unexpected event value %0d, required no event", nm, v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val != v) begin
        n_bad++;
        $display("FAIL %s: got event %0d value %0d, required event %0d value %0d",
                 nm, k, v, e.kind, e.val);
      end
    end
  endtask

  task automatic run_probe(input prb_s p);
    n_cmp++;
    case (p.kind)
      P_CRED: if (int'(credit) != p.val) begin
        n_bad++;
        $display("FAIL credit: got %0d, required %0d", credit, p.val);
      end
      P_RST: if ({credit, disp_req, disp_id, pay_req, pay_val, busy,
                  coin_rej, err_soldout, err_funds} != '0) begin
        n_bad++;
        $display("FAIL reset_outputs: got credit=%0d disp_req=%0b disp_id=%0d pay_req=%0b pay_val=%0d busy=%0b rej=%0b sold=%0b funds=%0b, required all 0",
                 credit, disp_req, disp_id, pay_req, pay_val, busy, coin_rej, err_soldout, err_funds);
      end
      P_IDLE: if (busy || disp_req || pay_req) begin
        n_bad++;
        $display("FAIL idle: got busy=%0b disp_req=%0b pay_req=%0b, required 0 0 0",
                 busy, disp_req, pay_req);
      end
      P_BUSY: if (!busy) begin
        n_bad++;
        $display("FAIL busy: got %0b, required 1", busy);
      end
      default: begin
        n_bad++;
        $display("FAIL timeout: handshake request %0d not raised, required within 20 cycles", p.val);
      end
    endcase
  endtask

  always @(negedge clk) begin
    if (coin_rej)               take(E_REJ,   0, "coin_rej");
    if (err_soldout)            take(E_SOLD,  0, "err_soldout");
    if (err_funds)              take(E_FUNDS, 0, "err_funds");
    if (disp_req && !disp_prev) take(E_DISP,  int'(disp_id), "disp_id");
    if (pay_req && pay_ack)     take(E_PAY,   int'(pay_val), "pay_val");
    disp_prev <= disp_req;
    if (probe) begin
      while (prb_q.size() > 0) run_probe(prb_q.pop_front());
    end
    if (done) begin
      while (exp_q.size() > 0) begin
        evt_s e;
        e = exp_q.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL missing_event: got nothing, required event %0d value %0d", e.kind, e.val);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1; coin = 2'b00; sel_vld = 1'b0; sel_id = 2'd0; cancel = 1'b0;
    restock = 1'b0; disp_ack = 1'b0; pay_ack = 1'b0;
    // slot3 = 0 (acts as 1), slot2 = 3, slot1 = 4, slot0 = 2
    price_cfg = {4'd0, 4'd3, 4'd4, 4'd2};
    tick();
    tick();
    rst = 1'b0;
    check(P_RST, 0);

    // Basic purchase: 5 units, slot1 costs 4, one half-yuan change.
    pulse_restock();
    put_coin(2'b10); put_coin(2'b10); put_coin(2'b01);
    check(P_CRED, 5);
    expect_evt(E_DISP, 1);
    select(2'd1);
    check(P_CRED, 1);
    expect_evt(E_PAY, 1);
    ack_dispense();
    pay_out(1);
    check(P_CRED, 0);
    check(P_IDLE, 0);

    // Change sequence 10, 10, 01 after buying slot0 with 7 units.
    put_coin(2'b10); put_coin(2'b10); put_coin(2'b10); put_coin(2'b01);
    expect_evt(E_DISP, 0);
    select(2'd0);
    check(P_CRED, 5);
    expect_evt(E_PAY, 2); expect_evt(E_PAY, 2); expect_evt(E_PAY, 1);
    ack_dispense();
    pay_out(3);
    check(P_CRED, 0);
    check(P_IDLE, 0);

    // Insufficient funds: credit 2, slot2 costs 3.
    put_coin(2'b10);
    expect_evt(E_FUNDS, 0);
    select(2'd2);
    check(P_CRED, 2);
    check(P_IDLE, 0);

    // Sold out: reset clears stock, no restock.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check(P_RST, 0);
    put_coin(2'b10);
    expect_evt(E_SOLD, 0);
    select(2'd0);
    check(P_CRED, 2);
    check(P_IDLE, 0);

    // Coin while dispensing is rejected; credit untouched.
    pulse_restock();
    expect_evt(E_DISP, 0);
    select(2'd0);
    check(P_CRED, 0);
    expect_evt(E_REJ, 0);
    put_coin(2'b10);
    check(P_CRED, 0);
    check(P_BUSY, 0);
    ack_dispense();
    check(P_IDLE, 0);

    // Credit ceiling: 30 + 2 rejected, 30 + 1 accepted, 31 + 1 rejected.
    for (int i = 0; i < 15; i++) put_coin(2'b10);
    check(P_CRED, 30);
    expect_evt(E_REJ, 0);
    put_coin(2'b10);
    check(P_CRED, 30);
    put_coin(2'b01);
    check(P_CRED, 31);
    expect_evt(E_REJ, 0);
    put_coin(2'b01);
    check(P_CRED, 31);
    for (int i = 0; i < 15; i++) expect_evt(E_PAY, 2);
    expect_evt(E_PAY, 1);
    pulse_cancel();
    pay_out(16);
    check(P_CRED, 0);
    check(P_IDLE, 0);

    // Cancel beats a same-cycle selection: refund 4 units, no dispense.
    put_coin(2'b10); put_coin(2'b10);
    expect_evt(E_PAY, 2); expect_evt(E_PAY, 2);
    sel_id = 2'd1; sel_vld = 1'b1; cancel = 1'b1;
    tick();
    sel_vld = 1'b0; cancel = 1'b0;
    pay_out(2);
    check(P_CRED, 0);
    check(P_IDLE, 0);

    // Coin and selection together: 4 + 1 - 4 = 1.
    put_coin(2'b10); put_coin(2'b10);
    expect_evt(E_DISP, 1);
    coin = 2'b01; sel_id = 2'd1; sel_vld = 1'b1;
    tick();
    coin = 2'b00; sel_vld = 1'b0;
    check(P_CRED, 1);
    expect_evt(E_PAY, 1);
    ack_dispense();
    pay_out(1);
    check(P_CRED, 0);

    // Reset in the middle of a payout; a late ack changes nothing.
    put_coin(2'b10); put_coin(2'b10);
    pulse_cancel();
    check(P_BUSY, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check(P_RST, 0);
    pay_ack = 1'b1;
    tick();
    pay_ack = 1'b0;
    check(P_RST, 0);

    // Zero price acts as one unit; slot3 empties after exactly 15 sales.
    pulse_restock();
    for (int i = 0; i < 15; i++) begin
      put_coin(2'b01);
      expect_evt(E_DISP, 3);
      select(2'd3);
      ack_dispense();
    end
    check(P_CRED, 0);
    put_coin(2'b01);
    expect_evt(E_SOLD, 0);
    select(2'd3);
    check(P_CRED, 1);
    expect_evt(E_PAY, 1);
    pulse_cancel();
    pay_out(1);
    check(P_IDLE, 0);

    tick();
    tick();
    done = 1'b1;
    tick();
    tick();
  end

endmodule
